// File: rtl/io_bus_bridge.sv
// io_bus_bridge: sequences one decoded CPU I/O request into a timed device
// cycle (chip select, setup, strobe, BUSYn wait, read capture) and returns a
// one-cycle active-low READYn. All state advances only on CE cycles.
module io_bus_bridge #(
    parameter int unsigned NCH     = 8,
    parameter int unsigned DW      = 16,
    parameter int unsigned SETUP   = 1,
    parameter int unsigned STROBE  = 2,
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned SW      = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              CLK,
    input  logic              RESn,
    input  logic              CE,
    input  logic              REQ,
    input  logic [SW-1:0]     SEL,
    input  logic              RW,
    input  logic [DW-1:0]     WDATA,
    output logic [DW-1:0]     RDATA,
    output logic              READYn,
    output logic [NCH-1:0]    CSn,
    output logic              RDn,
    output logic              WRn,
    output logic [DW-1:0]     DEV_DI,
    input  logic [NCH*DW-1:0] DEV_DO,
    input  logic [NCH-1:0]    DEV_BUSYn,
    output logic              TOERR,
    output logic [7:0]        ERR_CNT
);

    // One shared phase counter covers setup, strobe and wait lengths.
    localparam int unsigned MAXA = (SETUP > STROBE) ? SETUP : STROBE;
    localparam int unsigned MAXC = (MAXA > TIMEOUT) ? MAXA : TIMEOUT;
    localparam int unsigned CW   = (MAXC > 1) ? $clog2(MAXC + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_STROBE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [SW-1:0]   sel_q, sel_d;
    logic            rw_q, rw_d;
    logic [NCH-1:0]  csn_q, csn_d;
    logic            rdn_q, rdn_d;
    logic            wrn_q, wrn_d;
    logic            rdyn_q, rdyn_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic [DW-1:0]   di_q, di_d;
    logic            toerr_q, toerr_d;
    logic [7:0]      errcnt_q, errcnt_d;

    logic [NCH-1:0]  cs_sel_c;
    logic [DW-1:0]   dev_rd_c;
    logic            busy_sel_c;
    logic            mapped_c;

    // Channel decode: chip-select pattern for the request, read data and busy of the latched channel.
    always_comb begin
        cs_sel_c   = '1;
        dev_rd_c   = '0;
        busy_sel_c = 1'b0;
        for (int i = 0; i < int'(NCH); i++) begin
            if (SEL == SW'(i)) cs_sel_c[i] = 1'b0;
            if (sel_q == SW'(i)) begin
                dev_rd_c   = DEV_DO[i*DW +: DW];
                busy_sel_c = DEV_BUSYn[i];
            end
        end
        mapped_c = (32'(SEL) < NCH);
    end

    // State and output registers; CE=0 freezes everything.
    always_ff @(posedge CLK or negedge RESn) begin
        if (!RESn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            sel_q    <= '0;
            rw_q     <= 1'b0;
            csn_q    <= '1;
            rdn_q    <= 1'b1;
            wrn_q    <= 1'b1;
            rdyn_q   <= 1'b1;
            rdata_q  <= '0;
            di_q     <= '0;
            toerr_q  <= 1'b0;
            errcnt_q <= '0;
        end else if (CE) begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            rw_q     <= rw_d;
            csn_q    <= csn_d;
            rdn_q    <= rdn_d;
            wrn_q    <= wrn_d;
            rdyn_q   <= rdyn_d;
            rdata_q  <= rdata_d;
            di_q     <= di_d;
            toerr_q  <= toerr_d;
            errcnt_q <= errcnt_d;
        end
    end

    // Next state; outputs are computed for the state being entered.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sel_d    = sel_q;
        rw_d     = rw_q;
        csn_d    = csn_q;
        rdn_d    = rdn_q;
        wrn_d    = wrn_q;
        rdyn_d   = 1'b1;
        rdata_d  = rdata_q;
        di_d     = di_q;
        toerr_d  = 1'b0;
        errcnt_d = errcnt_q;
        unique case (state_q)
            S_IDLE: begin
                if (REQ) begin
                    sel_d = SEL;
                    rw_d  = RW;
                    di_d  = WDATA;
                    cnt_d = '0;
                    if (mapped_c) begin
                        csn_d = cs_sel_c;
                        if (SETUP == 0) begin
                            state_d = S_STROBE;
                            rdn_d   = ~RW;
                            wrn_d   = RW;
                        end else begin
                            state_d = S_SETUP;
                        end
                    end else begin
                        state_d = S_DONE;
                        rdyn_d  = 1'b0;
                        if (RW) rdata_d = '0;
                    end
                end
            end
            S_SETUP: begin
                if (cnt_q == CW'(SETUP - 1)) begin
                    cnt_d   = '0;
                    state_d = S_STROBE;
                    rdn_d   = ~rw_q;
                    wrn_d   = rw_q;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_STROBE: begin
                if (cnt_q == CW'(STROBE - 1)) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_WAIT: begin
                if (busy_sel_c) begin
                    if (rw_q) rdata_d = dev_rd_c;
                    rdn_d   = 1'b1;
                    wrn_d   = 1'b1;
                    rdyn_d  = 1'b0;
                    state_d = S_DONE;
                end else if ((TIMEOUT != 0) && (cnt_q == CW'(TIMEOUT - 1))) begin
                    if (rw_q) rdata_d = '1;
                    toerr_d = 1'b1;
                    if (errcnt_q != 8'hFF) errcnt_d = errcnt_q + 8'd1;
                    rdn_d   = 1'b1;
                    wrn_d   = 1'b1;
                    rdyn_d  = 1'b0;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                csn_d   = '1;
                cnt_d   = '0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign RDATA   = rdata_q;
    assign READYn  = rdyn_q;
    assign CSn     = csn_q;
    assign RDn     = rdn_q;
    assign WRn     = wrn_q;
    assign DEV_DI  = di_q;
    assign TOERR   = toerr_q;
    assign ERR_CNT = errcnt_q;

endmodule
